// File: rtl/ring_round_robin_scheduler.sv
// Round-robin grant of one shared resource using a rotating one-hot priority token.
// Grant appears 1 cycle after arbitration; no backpressure, a grant ends on release, request drop or dwell timeout.
module ring_round_robin_scheduler #(
    parameter int NUM_REQUESTERS = 8,
    parameter int DWELL_WIDTH    = 8
) (
    input  logic                              Clk_In,
    input  logic                              Reset_In,
    input  logic                              Enable_In,
    input  logic                              Start_Scheduler_Command_In,
    input  logic                              Stop_Scheduler_Command_In,
    input  logic [NUM_REQUESTERS-1:0]         Request_In,
    input  logic [NUM_REQUESTERS-1:0]         Release_In,
    input  logic [DWELL_WIDTH-1:0]            Max_Dwell_Cycles_In,
    output logic                              Scheduler_Running_Flag_Out,
    output logic [NUM_REQUESTERS-1:0]         Grant_Out,
    output logic                              Grant_Valid_Out,
    output logic [$clog2(NUM_REQUESTERS)-1:0] Grant_Index_Out,
    output logic                              Timeout_Flag_Out
);
    localparam int N     = NUM_REQUESTERS;
    localparam int IDX_W = $clog2(NUM_REQUESTERS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   running_q, running_d;
    logic [N-1:0]           grant_q, grant_d;
    logic [N-1:0]           token_q, token_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic                   timeout_q, timeout_d;

    logic [IDX_W-1:0]       tok_idx;
    logic [2*N-1:0]         req_dbl;
    logic [N-1:0]           req_rot;
    logic [IDX_W-1:0]       rot_off;
    logic [IDX_W:0]         pick_sum;
    logic [IDX_W-1:0]       pick_idx;
    logic [N-1:0]           pick_oh;

    logic                   rel_hit;
    logic                   req_held;
    logic                   dwell_hit;
    logic                   grant_end;

    logic                   grant_vld;
    logic [IDX_W-1:0]       grant_idx;

    always_comb begin
        tok_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (token_q[i]) tok_idx = IDX_W'(i);
        end
    end

    // Rotate requests so the token position sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_dbl  = {Request_In, Request_In} >> tok_idx;
        req_rot  = req_dbl[N-1:0];
        rot_off  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) rot_off = IDX_W'(i);
        end
        pick_sum = {1'b0, tok_idx} + {1'b0, rot_off};
        if (pick_sum >= (IDX_W + 1)'(N)) pick_sum = pick_sum - (IDX_W + 1)'(N);
        pick_idx = pick_sum[IDX_W-1:0];
        pick_oh  = '0;
        for (int i = 0; i < N; i++) begin
            pick_oh[i] = (pick_idx == IDX_W'(i));
        end
    end

    assign rel_hit   = |(Release_In & grant_q);
    assign req_held  = |(Request_In & grant_q);
    assign dwell_hit = (dwell_q != '0) && (cnt_q == dwell_q - DWELL_WIDTH'(1));
    assign grant_end = rel_hit || !req_held || dwell_hit;

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            grant_q   <= '0;
            token_q   <= N'(1);
            cnt_q     <= '0;
            dwell_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            grant_q   <= grant_d;
            token_q   <= token_d;
            cnt_q     <= cnt_d;
            dwell_q   <= dwell_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        running_d = running_q;
        if (Start_Scheduler_Command_In)     running_d = 1'b1;
        else if (Stop_Scheduler_Command_In) running_d = 1'b0;

        state_d   = state_q;
        grant_d   = grant_q;
        token_d   = token_q;
        cnt_d     = cnt_q;
        dwell_d   = dwell_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start_Scheduler_Command_In) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (Stop_Scheduler_Command_In && !Start_Scheduler_Command_In) begin
                    state_d = ST_IDLE;
                end else if (|Request_In) begin
                    state_d = ST_GRANT;
                    grant_d = pick_oh;
                    cnt_d   = '0;
                    dwell_d = Max_Dwell_Cycles_In;
                end
            end
            ST_GRANT: begin
                if (grant_end) begin
                    // A release or request drop coinciding with the dwell limit is not a timeout.
                    state_d   = running_d ? ST_ARB : ST_IDLE;
                    grant_d   = '0;
                    token_d   = {grant_q[N-2:0], grant_q[N-1]};
                    timeout_d = dwell_hit && !rel_hit && req_held;
                end else begin
                    cnt_d = cnt_q + DWELL_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        grant_vld = |grant_q;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) grant_idx = IDX_W'(i);
        end
    end

    assign Scheduler_Running_Flag_Out = Enable_In ? running_q : 1'bz;
    assign Grant_Out                  = Enable_In ? grant_q   : {N{1'bz}};
    assign Grant_Valid_Out            = Enable_In ? grant_vld : 1'bz;
    assign Grant_Index_Out            = Enable_In ? grant_idx : {IDX_W{1'bz}};
    assign Timeout_Flag_Out           = Enable_In ? timeout_q : 1'bz;

endmodule

// File: tb/tb_ring_round_robin_scheduler.sv
// Bench for ring_round_robin_scheduler with 4 requesters: directed scenarios plus
// a randomized run, all compared cycle by cycle against a behavioural model.
module tb_ring_round_robin_scheduler;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int VW = N + IW + 3;

    logic          tb_Clk_In = 1'b0;
    logic          tb_Reset_In;
    logic          tb_Enable_In;
    logic          tb_Start;
    logic          tb_Stop;
    logic [N-1:0]  tb_Request_In;
    logic [N-1:0]  tb_Release_In;
    logic [DW-1:0] tb_Max_Dwell;

    wire           run_w;
    wire [N-1:0]   gnt_w;
    wire           gv_w;
    wire [IW-1:0]  idx_w;
    wire           to_w;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 arbitrating, 2 granting; m_gnt = -1 means no grant.
    bit m_run;
    int m_phase;
    int m_tok;
    int m_gnt;
    int m_age;
    int m_lim;
    bit m_to;

    ring_round_robin_scheduler #(
        .NUM_REQUESTERS(N),
        .DWELL_WIDTH   (DW)
    ) dut (
        .Clk_In                    (tb_Clk_In),
        .Reset_In                  (tb_Reset_In),
        .Enable_In                 (tb_Enable_In),
        .Start_Scheduler_Command_In(tb_Start),
        .Stop_Scheduler_Command_In (tb_Stop),
        .Request_In                (tb_Request_In),
        .Release_In                (tb_Release_In),
        .Max_Dwell_Cycles_In       (tb_Max_Dwell),
        .Scheduler_Running_Flag_Out(run_w),
        .Grant_Out                 (gnt_w),
        .Grant_Valid_Out           (gv_w),
        .Grant_Index_Out           (idx_w),
        .Timeout_Flag_Out          (to_w)
    );

    always #5 tb_Clk_In = ~tb_Clk_In;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic model_reset();
        m_run = 1'b0; m_phase = 0; m_tok = 0; m_gnt = -1; m_age = 0; m_lim = 0; m_to = 1'b0;
    endtask

    task automatic model_step();
        bit run_n, rel, drop, tmo, found;
        int j;
        run_n = tb_Start ? 1'b1 : (tb_Stop ? 1'b0 : m_run);
        m_to  = 1'b0;
        if (m_phase == 0) begin
            if (tb_Start) m_phase = 1;
        end else if (m_phase == 1) begin
            if (tb_Stop && !tb_Start) m_phase = 0;
            else if (tb_Request_In != '0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    j = (m_tok + k) % N;
                    if (!found && tb_Request_In[j]) begin
                        m_gnt = j;
                        found = 1'b1;
                    end
                end
                m_age = 1; m_lim = int'(tb_Max_Dwell); m_phase = 2;
            end
        end else begin
            rel  = tb_Release_In[m_gnt];
            drop = !tb_Request_In[m_gnt];
            tmo  = (m_lim != 0) && (m_age == m_lim);
            if (rel || drop || tmo) begin
                m_to    = tmo && !rel && !drop;
                m_tok   = (m_gnt + 1) % N;
                m_gnt   = -1;
                m_phase = run_n ? 1 : 0;
            end else begin
                m_age++;
            end
        end
        m_run = run_n;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0]  g;
        logic [IW-1:0] ix;
        g  = '0;
        ix = '0;
        if (!tb_Enable_In) return {VW{1'bz}};
        if (m_gnt >= 0) begin
            g[m_gnt] = 1'b1;
            ix = IW'(m_gnt);
        end
        return {m_run, (m_gnt >= 0), ix, g, m_to};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {run_w, gv_w, idx_w, gnt_w, to_w};
    endfunction

    task automatic tick();
        @(posedge tb_Clk_In);
        if (tb_Reset_In) model_reset();
        else model_step();
        @(negedge tb_Clk_In);
    endtask

    task automatic idle_inputs();
        tb_Enable_In = 1'b1; tb_Start = 1'b0; tb_Stop = 1'b0;
        tb_Request_In = '0; tb_Release_In = '0; tb_Max_Dwell = '0;
    endtask

    task automatic do_reset_start();
        idle_inputs();
        tb_Reset_In = 1'b1;
        model_reset();
        tick(); tick();
        tb_Reset_In = 1'b0;
        tb_Start = 1'b1;
        tick();
        tb_Start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        tb_Reset_In = 1'b1;
        model_reset();
        tick(); tick();
        if (obs_vec() !== {VW{1'b0}}) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", obs_vec(), {VW{1'b0}});
        end
        checks++;
        tb_Reset_In = 1'b0;
        tb_Start = 1'b1;
        tick();
        tb_Start = 1'b0;
        if (run_w !== 1'b1) begin
            errors++; $display("FAIL start_running: got %b expected 1", run_w);
        end
        checks++;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL no_request cyc %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            checks++;
        end
        if (gnt_w !== 4'b0000) begin
            errors++; $display("FAIL no_request_grant: got %b expected 0000", gnt_w);
        end
        checks++;
    endtask

    task automatic test_rotation();
        logic [N-1:0] exp_seq [5];
        logic [N-1:0] seq [$];
        logic [N-1:0] prev;
        int tos, held;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev = '0; tos = 0; held = 0;
        do_reset_start();
        tb_Request_In = 4'b1111;
        tb_Max_Dwell  = 8'd3;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rotation cyc %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            checks++;
            if (gnt_w !== 4'b0000 && prev === 4'b0000) seq.push_back(gnt_w);
            if (gnt_w !== 4'b0000) held++;
            if (to_w === 1'b1) tos++;
            prev = gnt_w;
        end
        for (int i = 0; i < 5; i++) begin
            if (i >= seq.size() || seq[i] !== exp_seq[i]) begin
                errors++; $display("FAIL rotation_order grant %0d: got %b expected %b", i,
                                   (i < seq.size()) ? seq[i] : 4'bxxxx, exp_seq[i]);
            end
            checks++;
        end
        if (tos != 5) begin
            errors++; $display("FAIL rotation_timeouts: got %0d expected 5", tos);
        end
        checks++;
        if (held != 15) begin
            errors++; $display("FAIL rotation_grant_cycles: got %0d expected 15", held);
        end
        checks++;
    endtask

    task automatic test_release();
        logic [N-1:0] exp_seq [3];
        logic [N-1:0] seq [$];
        logic [N-1:0] prev;
        exp_seq = '{4'b0010, 4'b1000, 4'b0010};
        prev = '0;
        do_reset_start();
        tb_Request_In = 4'b1010;
        tb_Max_Dwell  = 8'd8;
        for (int c = 0; c < 30; c++) begin
            tb_Release_In = (c == 2) ? 4'b0010 : 4'b0000;
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL release cyc %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            checks++;
            if (c == 0 && idx_w !== 2'd1) begin
                errors++; $display("FAIL release_first_index: got %0d expected 1", idx_w);
            end
            if (c == 0) checks++;
            if (c == 2 && (gnt_w !== 4'b0000 || to_w !== 1'b0)) begin
                errors++; $display("FAIL release_drop: got grant %b timeout %b expected 0000 0", gnt_w, to_w);
            end
            if (c == 2) checks++;
            if (gnt_w !== 4'b0000 && prev === 4'b0000) seq.push_back(gnt_w);
            prev = gnt_w;
        end
        tb_Release_In = '0;
        for (int i = 0; i < 3; i++) begin
            if (i >= seq.size() || seq[i] !== exp_seq[i]) begin
                errors++; $display("FAIL release_order grant %0d: got %b expected %b", i,
                                   (i < seq.size()) ? seq[i] : 4'bxxxx, exp_seq[i]);
            end
            checks++;
        end
    endtask

    task automatic test_unlimited();
        int held, tos;
        held = 0; tos = 0;
        do_reset_start();
        tb_Max_Dwell  = 8'd0;
        tb_Request_In = 4'b0100;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL unlimited cyc %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            checks++;
            if (gnt_w === 4'b0100) held++;
            if (to_w === 1'b1) tos++;
        end
        tb_Request_In = 4'b0000;
        tick();
        if (gnt_w !== 4'b0000 || to_w !== 1'b0) begin
            errors++; $display("FAIL unlimited_drop: got grant %b timeout %b expected 0000 0", gnt_w, to_w);
        end
        checks++;
        if (held != 300 || tos != 0) begin
            errors++; $display("FAIL unlimited_hold: got %0d cycles %0d timeouts expected 300 0", held, tos);
        end
        checks++;
    endtask

    task automatic test_stop();
        int held;
        held = 0;
        do_reset_start();
        tb_Request_In = 4'b1111;
        tb_Max_Dwell  = 8'd3;
        tick();
        tb_Stop = 1'b1;
        tick();
        tb_Stop = 1'b0;
        if (run_w !== 1'b0 || gnt_w !== 4'b0001) begin
            errors++; $display("FAIL stop_mid_grant: got run %b grant %b expected 0 0001", run_w, gnt_w);
        end
        checks++;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL stop cyc %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            checks++;
            if (gnt_w !== 4'b0000) held++;
        end
        if (held != 1 || gnt_w !== 4'b0000) begin
            errors++; $display("FAIL stop_idle: got %0d extra grant cycles, grant %b expected 1 0000", held, gnt_w);
        end
        checks++;
        tb_Start = 1'b1; tb_Stop = 1'b1;
        tick();
        tb_Start = 1'b0; tb_Stop = 1'b0;
        if (run_w !== 1'b1) begin
            errors++; $display("FAIL start_stop_together: got %b expected 1", run_w);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        do_reset_start();
        tb_Request_In = 4'b0100;
        tick();
        tb_Request_In = 4'b0000;
        tick();
        tb_Request_In = 4'b0100;
        tick();
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL async_pre: got %b expected %b", obs_vec(), exp_vec());
        end
        checks++;
        #2 tb_Reset_In = 1'b1;
        #1;
        if (gnt_w !== 4'b0000 || gv_w !== 1'b0) begin
            errors++; $display("FAIL async_reset: got grant %b valid %b expected 0000 0", gnt_w, gv_w);
        end
        checks++;
        model_reset();
        tick();
        tb_Reset_In   = 1'b0;
        tb_Start      = 1'b1;
        tb_Request_In = 4'b1111;
        tb_Max_Dwell  = 8'd2;
        tick();
        tb_Start = 1'b0;
        tick();
        if (gnt_w !== 4'b0001) begin
            errors++; $display("FAIL token_reset: got %b expected 0001", gnt_w);
        end
        checks++;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL async_post cyc %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_enable();
        do_reset_start();
        tb_Request_In = 4'b0010;
        tick();
        tb_Enable_In = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) tb_Request_In = 4'b0000;
            if (k == 3) tb_Request_In = 4'b1000;
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL enable_off cyc %0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
            checks++;
        end
        tb_Enable_In = 1'b1;
        #1;
        if (obs_vec() !== exp_vec() || gnt_w !== 4'b1000) begin
            errors++; $display("FAIL enable_return: got %b expected %b", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_random();
        do_reset_start();
        for (int c = 0; c < 3000; c++) begin
            tb_Request_In = N'($urandom);
            tb_Release_In = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            tb_Start      = ($urandom_range(0, 49) == 0);
            tb_Stop       = ($urandom_range(0, 49) == 0);
            tb_Max_Dwell  = DW'($urandom_range(0, 6));
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random cyc %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            checks++;
        end
        idle_inputs();
    endtask

    initial begin
        tb_Reset_In = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_rotation();
        test_release();
        test_unlimited();
        test_stop();
        test_async_reset();
        test_enable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_round_robin_scheduler.md
Name: ring_round_robin_scheduler

Overview:
Round-robin scheduler that shares one resource among NUM_REQUESTERS clients using a rotating one-hot priority token, the same ring-rotation principle as our ring counters. It has start/stop command control and a running flag, like our counter blocks. Each grant ends on release, on request withdrawal, or on a programmable dwell timeout. It sits between the requesting clients and the shared datapath.

Parameters:
NUM_REQUESTERS, 8, number of requesters; minimum 2.
DWELL_WIDTH, 8, width of the dwell limit and the dwell counter.

Ports:
Clk_In  input  1  clock; all state updates on the rising edge.
Reset_In  input  1  asynchronous, active-high reset.
Enable_In  input  1  output enable; when 0, all outputs are Z and internal state keeps running.
Start_Scheduler_Command_In  input  1  start command, sampled on the clock edge.
Stop_Scheduler_Command_In  input  1  stop command, sampled on the clock edge.
Request_In  input  NUM_REQUESTERS  per-requester request level.
Release_In  input  NUM_REQUESTERS  per-requester early release; only the bit of the current grantee is used.
Max_Dwell_Cycles_In  input  DWELL_WIDTH  grant length limit in cycles; 0 means unlimited.
Scheduler_Running_Flag_Out  output  1  scheduler running.
Grant_Out  output  NUM_REQUESTERS  one-hot grant, or all zeros.
Grant_Valid_Out  output  1  equals the OR of Grant_Out.
Grant_Index_Out  output  clog2(NUM_REQUESTERS)  binary index of the grantee; 0 when no grant.
Timeout_Flag_Out  output  1  one-cycle pulse when a grant is terminated by the dwell limit.

Behaviour:
- Reset (asynchronous, immediate, including mid-grant):
  - state = IDLE; running flag = 0; Grant_Out = 0; Grant_Valid_Out = 0; Grant_Index_Out = 0; Timeout_Flag_Out = 0.
  - Token = 1 (requester 0 has highest priority); dwell counter = 0; latched dwell = 0.
- Running flag:
  - Start sets the flag at the next edge.
  - Stop clears it at the next edge.
  - Start and Stop in the same cycle: Start wins.
  - Start while already running: no effect.
- States:
  - IDLE: no grant. On Start -> ARB.
  - ARB: if any Request_In bit is set, pick the first set bit at or after the token position, scanning upward with wrap from bit N-1 to bit 0. At the next edge, assert that grant, clear the dwell counter, latch Max_Dwell_Cycles_In and go to GRANT. With no requests, stay in ARB with no grant. Stop while in ARB -> IDLE at the next edge, no grant issued.
  - GRANT: grant held; dwell counter increments every cycle. The grant terminates at an edge where any of the following holds:
    (a) Release_In of the grantee is 1;
    (b) Request_In of the grantee is 0;
    (c) latched dwell != 0 and the grant has been asserted for latched-dwell cycles. Timeout_Flag_Out pulses during the first cycle after the grant drops.
  - On termination: Grant_Out = 0; token = grant rotated left by 1, with wrap; next state is ARB, or IDLE if the running flag is 0.
- Latency and timing:
  - Request to grant: 1 cycle from ARB.
  - Every grant is followed by at least one idle ARB cycle, so there are never back-to-back grants.
  - A grant of exactly 1 cycle occurs when latched dwell = 1.
- Stop during GRANT: the current grant completes normally; the running flag clears immediately.
- Simultaneous termination events: release or request drop together with timeout counts as a release; no Timeout pulse.
- Max_Dwell_Cycles_In changes during a grant have no effect until the next grant.
- Requests that change during GRANT do not affect the current grant; they are considered at the next ARB.
- Release_In and Request_In bits of non-granted requesters are ignored during GRANT.
- Enable_In = 0 puts every output at Z. State, token and counter continue to evolve; outputs reappear correctly in the same cycle Enable_In returns to 1.

Test Plan:
1. Reset with Enable_In = 1 -> all outputs 0; Start with Request_In = 4'b0000 -> Scheduler_Running_Flag_Out = 1, Grant_Out = 0 indefinitely.
2. NUM_REQUESTERS = 4, Request_In = 4'b1111, Max_Dwell = 3, no releases -> grants 0001, 0010, 0100, 1000, 0001 in order. Each grant lasts 3 cycles, with a 1-cycle gap and a Timeout pulse after each.
3. Request_In = 4'b1010, token at 0 -> first grant 0010, index 1. Release_In = 4'b0010 on cycle 2 -> grant drops with no Timeout. The next grant is 1000 (index 3), then wraps back to 0010.
4. Max_Dwell = 0, requester 2 holds its request for 300 cycles -> 0100 stays granted for 300 cycles with no Timeout. Requester 2 drops its request -> grant ends at the next edge.
5. Stop asserted mid-grant (cycle 1 of 3), requests still present -> running flag is 0 the next cycle. The grant holds to its natural end, then stays 0 (IDLE). Start and Stop asserted together afterwards -> running flag = 1.
6. Reset asserted asynchronously mid-grant -> Grant_Out = 0 and Grant_Valid_Out = 0 immediately, token back to 1. Enable_In = 0 during a grant -> all outputs Z; Enable_In = 1 again -> outputs match the internal state.
